// File: rtl/btn_sel_pkg.sv
// Shared defaults and sizing helper for the button selection controller.
// Pure constants and functions: no latency, no flow control.
package btn_sel_pkg;

  localparam int DEF_NUM_BTN     = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEB_CNT     = 1048575;
  localparam int DEF_SEL_W       = 2;
  localparam int DEF_LONG_CNT    = 50000000;

  // Width of a counter that must reach count-1; never narrower than one bit.
  function automatic int cnt_width(input int count);
    return (count < 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: synchroniser, debounce counter, level and press-edge registers.
// Latency SYNC_STAGES+DEB_CNT+1 from btn edge to press; no backpressure.
module btn_debounce
  import btn_sel_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_CNT     = DEF_DEB_CNT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_level,
  output logic press,
  output logic rise
);

  localparam int            CW       = cnt_width(DEB_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt;
  logic                   lvl_d;

  assign sync = sync_q[SYNC_STAGES-1];
  // rise lets the parent update its state in the same edge that press asserts
  assign rise = btn_level & ~lvl_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      cnt       <= '0;
      btn_level <= 1'b0;
      lvl_d     <= 1'b0;
      press     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      if (sync == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_level <= sync;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      lvl_d <= btn_level;
      press <= rise;
    end
  end

endmodule

// File: rtl/btn_sel_ctrl.sv
// Debounced multi-button selector with per-channel wrapping counters; optional long press via BTN_LONGPRESS_EN.
// Press latency SYNC_STAGES+DEB_CNT+1 cycles, long press LONG_CNT cycles after level rises; no backpressure.
module btn_sel_ctrl
  import btn_sel_pkg::*;
#(
  parameter int NUM_BTN     = DEF_NUM_BTN,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_CNT     = DEF_DEB_CNT,
  parameter int SEL_W       = DEF_SEL_W,
  parameter int LONG_CNT    = DEF_LONG_CNT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_BTN-1:0]       btn,
  input  logic [NUM_BTN*SEL_W-1:0] sel_max,
  output logic [NUM_BTN-1:0]       btn_level,
  output logic [NUM_BTN-1:0]       press,
  output logic [NUM_BTN-1:0]       long_press,
  output logic [NUM_BTN*SEL_W-1:0] sel
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic             rise;
    logic             long_hit;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] max_i;

    assign max_i = sel_max[i*SEL_W +: SEL_W];

    btn_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CNT    (DEB_CNT)
    ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .btn      (btn[i]),
      .btn_level(btn_level[i]),
      .press    (press[i]),
      .rise     (rise)
    );

`ifdef BTN_LONGPRESS_EN
    localparam int            HW        = cnt_width(LONG_CNT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CNT - 1);

    logic [HW-1:0] hold_cnt;
    logic          hold_done;
    logic          lp_q;

    // hold_done blocks further pulses until the debounced level drops
    assign long_hit      = btn_level[i] & ~hold_done & (hold_cnt == HOLD_LAST);
    assign long_press[i] = lp_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        hold_cnt  <= '0;
        hold_done <= 1'b0;
        lp_q      <= 1'b0;
      end else begin
        lp_q <= long_hit;
        if (!btn_level[i]) begin
          hold_cnt  <= '0;
          hold_done <= 1'b0;
        end else if (long_hit) begin
          hold_cnt  <= '0;
          hold_done <= 1'b1;
        end else if (!hold_done) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
`else
    assign long_hit      = 1'b0;
    assign long_press[i] = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        sel_q <= '0;
      end else if (long_hit) begin
        sel_q <= '0;
      end else if (rise) begin
        sel_q <= (sel_q >= max_i) ? '0 : sel_q + 1'b1;
      end
    end

    assign sel[i*SEL_W +: SEL_W] = sel_q;
  end

endmodule

// File: tb/tb_btn_sel_ctrl.sv
// Directed bench for btn_sel_ctrl with DEB_CNT=4, SYNC_STAGES=2, SEL_W=2, LONG_CNT=16, NUM_BTN=4.
// Expected values hand-derived; long-press expectations switch on BTN_LONGPRESS_EN.
module tb_btn_sel_ctrl;

`ifdef BTN_LONGPRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [7:0] sel_max;
  logic [3:0] btn_level;
  logic [3:0] press;
  logic [3:0] long_press;
  logic [7:0] sel;

  int n_chk;
  int n_pass;
  int press_cnt [4];
  int lp_cnt    [4];
  int p_snap;
  int l_snap;

  btn_sel_ctrl #(
    .NUM_BTN    (4),
    .SYNC_STAGES(2),
    .DEB_CNT    (4),
    .SEL_W      (2),
    .LONG_CNT   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .sel_max   (sel_max),
    .btn_level (btn_level),
    .press     (press),
    .long_press(long_press),
    .sel       (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] += int'(press[i]);
      lp_cnt[i]    += int'(long_press[i]);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] sel_of(input int i);
    return sel[i*2 +: 2];
  endfunction

  task automatic short_press(input int ch);
    btn[ch] = 1'b1;
    tick(8);
    btn[ch] = 1'b0;
    tick(10);
  endtask

  logic [1:0] wrap_exp [4];
  logic [7:0] sim_exp;

  initial begin
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0;
      lp_cnt[i]    = 0;
    end
    n_chk   = 0;
    n_pass  = 0;
    rst     = 1'b1;
    btn     = 4'h0;
    sel_max = {2'd3, 2'd2, 2'd3, 2'd3};
    tick(3);

    check("rst_level", 32'(btn_level), 32'h0);
    check("rst_press", 32'(press), 32'h0);
    check("rst_long", 32'(long_press), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    rst = 1'b0;
    tick(2);

    // clean press on channel 0
    p_snap = press_cnt[0];
    l_snap = lp_cnt[0];
    btn[0] = 1'b1;
    tick(6);
    check("clean_press_early", 32'(press[0]), 32'h0);
    tick(1);
    check("clean_press_at7", 32'(press[0]), 32'h1);
    check("clean_sel", 32'(sel_of(0)), 32'h1);
    check("clean_level", 32'(btn_level[0]), 32'h1);
    tick(1);
    check("clean_press_1cyc", 32'(press[0]), 32'h0);
    tick(12);
    btn[0] = 1'b0;
    tick(12);
    check("clean_level_fall", 32'(btn_level[0]), 32'h0);
    check("clean_press_count", 32'(press_cnt[0] - p_snap), 32'h1);
    check("clean_sel_end", 32'(sel_of(0)), LP ? 32'h0 : 32'h1);
    check("clean_long_count", 32'(lp_cnt[0] - l_snap), LP ? 32'h1 : 32'h0);

    // bouncing input on channel 1
    p_snap = press_cnt[1];
    for (int k = 0; k < 3; k++) begin
      btn[1] = 1'b1;
      tick(3);
      btn[1] = 1'b0;
      tick(1);
    end
    btn[1] = 1'b1;
    check("bounce_no_press", 32'(press_cnt[1] - p_snap), 32'h0);
    check("bounce_level", 32'(btn_level[1]), 32'h0);
    tick(6);
    check("bounce_press_early", 32'(press[1]), 32'h0);
    tick(1);
    check("bounce_press", 32'(press[1]), 32'h1);
    check("bounce_sel", 32'(sel_of(1)), 32'h1);
    tick(3);
    btn[1] = 1'b0;
    tick(10);
    check("bounce_press_count", 32'(press_cnt[1] - p_snap), 32'h1);

    // wrap on channel 2 with sel_max=2, then sel_max=0 (sel above max wraps to 0)
    wrap_exp[0] = 2'd1;
    wrap_exp[1] = 2'd2;
    wrap_exp[2] = 2'd0;
    wrap_exp[3] = 2'd1;
    for (int k = 0; k < 4; k++) begin
      short_press(2);
      check($sformatf("wrap_max2_%0d", k), 32'(sel_of(2)), 32'(wrap_exp[k]));
    end
    sel_max[5:4] = 2'd0;
    for (int k = 0; k < 3; k++) begin
      short_press(2);
      check($sformatf("wrap_max0_%0d", k), 32'(sel_of(2)), 32'h0);
    end
    sel_max[5:4] = 2'd3;

    // simultaneous presses on all channels
    btn = 4'hF;
    tick(6);
    check("sim_press_early", 32'(press), 32'h0);
    tick(1);
    check("sim_press", 32'(press), 32'hF);
    sim_exp = {2'd1, 2'd1, 2'd2, (LP ? 2'd1 : 2'd2)};
    check("sim_sel", 32'(sel), 32'(sim_exp));
    btn = 4'h0;
    tick(12);

    // reset mid-debounce on channel 0
    btn[0] = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1);
    check("rstmid_level", 32'(btn_level), 32'h0);
    check("rstmid_press", 32'(press), 32'h0);
    check("rstmid_long", 32'(long_press), 32'h0);
    check("rstmid_sel", 32'(sel), 32'h0);
    rst = 1'b0;
    tick(6);
    check("rstmid_press_early", 32'(press[0]), 32'h0);
    tick(1);
    check("rstmid_press", 32'(press[0]), 32'h1);
    check("rstmid_sel0", 32'(sel_of(0)), 32'h1);
    tick(1);
    btn[0] = 1'b0;
    tick(12);

    // long hold on channel 0 starting from sel=2
    short_press(0);
    check("long_presel", 32'(sel_of(0)), 32'h2);
    p_snap = press_cnt[0];
    l_snap = lp_cnt[0];
    btn[0] = 1'b1;
    tick(7);
    check("long_press_pulse", 32'(press[0]), 32'h1);
    check("long_sel_after_press", 32'(sel_of(0)), 32'h3);
    tick(14);
    check("long_not_yet", 32'(long_press[0]), 32'h0);
    tick(1);
    check("long_pulse", 32'(long_press[0]), 32'(LP));
    check("long_sel_clear", 32'(sel_of(0)), LP ? 32'h0 : 32'h3);
    tick(1);
    check("long_pulse_1cyc", 32'(long_press[0]), 32'h0);
    tick(17);
    btn[0] = 1'b0;
    tick(12);
    check("long_count", 32'(lp_cnt[0] - l_snap), LP ? 32'h1 : 32'h0);
    check("long_press_count", 32'(press_cnt[0] - p_snap), 32'h1);
    check("long_sel_end", 32'(sel_of(0)), LP ? 32'h0 : 32'h3);
    check("long_total_other", 32'(lp_cnt[1] + lp_cnt[2] + lp_cnt[3]), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
